// File: rtl/aes_pkg.sv
// Shared AES reader definitions: block geometry and
// the reader FSM state encoding.
package aes_pkg;

    localparam int AES_BLOCK_BITS  = 128;
    localparam int BYTES_PER_BLOCK = 16;

    typedef enum logic [2:0] {
        RD_IDLE  = 3'd0,
        RD_FETCH = 3'd1,
        RD_DRAIN = 3'd2,
        RD_SEND  = 3'd3,
        RD_DONE  = 3'd4
    } rd_state_t;

endpackage

// File: rtl/block_packer.sv
// 16-byte shift-left packer: the first byte shifted in
// ends up in the most significant byte of the block.
module block_packer
    import aes_pkg::*;
(
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      i_clr,
    input  logic                      i_en,
    input  logic [7:0]                i_byte,
    output logic [AES_BLOCK_BITS-1:0] o_data
);

    logic [AES_BLOCK_BITS-1:0] r_data;

    // Clear has priority; otherwise shift a byte in from the bottom.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_data <= '0;
        end else if (i_clr) begin
            r_data <= '0;
        end else if (i_en) begin
            r_data <= {r_data[AES_BLOCK_BITS-9:0], i_byte};
        end
    end

    assign o_data = r_data;

endmodule

// File: rtl/image_block_reader.sv
// Streams an image from byte-wide memory as big-endian
// 128-bit blocks over a valid/ready interface.
module image_block_reader
    import aes_pkg::*;
#(
    parameter int IMG_BYTES = 4096,
    parameter int ADDR_W    = 12
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    output logic                      done,
    output logic                      busy,
    output logic                      mem_en,
    output logic [ADDR_W-1:0]         mem_addr,
    input  logic [7:0]                mem_rdata,
    output logic [AES_BLOCK_BITS-1:0] blk_data,
    output logic                      blk_valid,
    input  logic                      blk_ready
);

    localparam int NBLK  = IMG_BYTES / BYTES_PER_BLOCK;
    localparam int BLK_W = (ADDR_W > 4) ? ADDR_W - 4 : 1;
    localparam logic [BLK_W-1:0] LAST_BLK = BLK_W'(NBLK - 1);

    generate
        if (IMG_BYTES <= 0 || (IMG_BYTES % BYTES_PER_BLOCK) != 0 ||
            IMG_BYTES > (2 ** ADDR_W)) begin : g_bad_cfg
            $error("image_block_reader: bad IMG_BYTES/ADDR_W");
        end
    endgenerate

    rd_state_t         r_state, w_state;
    logic [3:0]        r_byte,  w_byte;
    logic [BLK_W-1:0]  r_blk,   w_blk;
    logic [ADDR_W-1:0] r_addr,  w_addr;
    logic              r_en,    w_en;
    logic              r_valid, w_valid;
    // High while mem_rdata holds a byte to be captured.
    logic              r_rd,    w_rd;
    logic              w_pk_clr;

    // State, counters and registered memory/handshake outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= RD_IDLE;
            r_byte  <= '0;
            r_blk   <= '0;
            r_addr  <= '0;
            r_en    <= 1'b0;
            r_valid <= 1'b0;
            r_rd    <= 1'b0;
        end else begin
            r_state <= w_state;
            r_byte  <= w_byte;
            r_blk   <= w_blk;
            r_addr  <= w_addr;
            r_en    <= w_en;
            r_valid <= w_valid;
            r_rd    <= w_rd;
        end
    end

    // Next-state and next-output logic; start low mid-run aborts.
    always_comb begin
        w_state = r_state;
        w_byte  = r_byte;
        w_blk   = r_blk;
        w_addr  = r_addr;
        w_en    = 1'b0;
        w_valid = 1'b0;
        w_rd    = r_en;
        unique case (r_state)
            RD_IDLE: begin
                w_byte = '0;
                w_blk  = '0;
                w_addr = '0;
                if (start) begin
                    w_state = RD_FETCH;
                    w_en    = 1'b1;
                end
            end
            RD_FETCH, RD_DRAIN, RD_SEND: begin
                if (!start) begin
                    w_state = RD_IDLE;
                    w_byte  = '0;
                    w_blk   = '0;
                    w_addr  = '0;
                    w_rd    = 1'b0;
                end else if (r_state == RD_FETCH) begin
                    if (r_byte == 4'hF) begin
                        w_state = RD_DRAIN;
                    end else begin
                        w_en   = 1'b1;
                        w_byte = r_byte + 4'd1;
                        w_addr = r_addr + 1'b1;
                    end
                end else if (r_state == RD_DRAIN) begin
                    w_state = RD_SEND;
                    w_valid = 1'b1;
                end else if (blk_ready) begin
                    if (r_blk == LAST_BLK) begin
                        w_state = RD_DONE;
                    end else begin
                        w_state = RD_FETCH;
                        w_en    = 1'b1;
                        w_byte  = '0;
                        w_blk   = r_blk + 1'b1;
                        w_addr  = r_addr + 1'b1;
                    end
                end else begin
                    w_valid = 1'b1;
                end
            end
            RD_DONE: begin
                if (!start) begin
                    w_state = RD_IDLE;
                end
            end
            default: begin
                w_state = RD_IDLE;
            end
        endcase
    end

    // The packer is wiped whenever the reader sits idle.
    always_comb begin
        w_pk_clr = (r_state == RD_IDLE);
    end

    block_packer u_packer (
        .clk    (clk),
        .rst    (rst),
        .i_clr  (w_pk_clr),
        .i_en   (r_rd),
        .i_byte (mem_rdata),
        .o_data (blk_data)
    );

    assign done      = (r_state == RD_DONE);
    assign busy      = (r_state == RD_FETCH) ||
                       (r_state == RD_DRAIN) ||
                       (r_state == RD_SEND);
    assign mem_en    = r_en;
    assign mem_addr  = r_addr;
    assign blk_valid = r_valid;

endmodule

// File: tb/tb_image_block_reader.sv
// Bench for image_block_reader: a 32-byte instance for timing and
// corner sequences, a 4096-byte instance for a random-ready stream.
module tb_image_block_reader;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    // 32-byte instance
    logic         start32 = 1'b0;
    logic         done32, busy32, en32, v32;
    logic [4:0]   a32;
    logic [7:0]   rd32;
    logic [127:0] d32;
    logic         rdy32 = 1'b1;

    image_block_reader #(.IMG_BYTES(32), .ADDR_W(5)) dut32 (
        .clk(clk), .rst(rst), .start(start32),
        .done(done32), .busy(busy32),
        .mem_en(en32), .mem_addr(a32), .mem_rdata(rd32),
        .blk_data(d32), .blk_valid(v32), .blk_ready(rdy32)
    );

    always @(posedge clk) if (en32) rd32 <= {3'b000, a32};

    // 4096-byte instance
    logic         start4k = 1'b0;
    logic         done4k, busy4k, en4k, v4k;
    logic [11:0]  a4k;
    logic [7:0]   rd4k;
    logic [127:0] d4k;
    logic         rdy4k = 1'b0;
    logic [7:0]   mem4k [4096];
    int           rc4k  [4096];
    int           hs4k = 0;

    image_block_reader #(.IMG_BYTES(4096), .ADDR_W(12)) dut4k (
        .clk(clk), .rst(rst), .start(start4k),
        .done(done4k), .busy(busy4k),
        .mem_en(en4k), .mem_addr(a4k), .mem_rdata(rd4k),
        .blk_data(d4k), .blk_valid(v4k), .blk_ready(rdy4k)
    );

    always @(posedge clk) begin
        if (en4k) begin
            rd4k     <= mem4k[a4k];
            rc4k[a4k] <= rc4k[a4k] + 1;
        end
    end

    logic [127:0] q32[$];
    logic [127:0] q4k[$];
    logic [127:0] e32, e4k;

    function automatic logic [127:0] blk32(input int b);
        logic [127:0] r;
        r = '0;
        for (int k = 0; k < 16; k++) r[127-8*k -: 8] = 8'(b*16 + k);
        return r;
    endfunction

    function automatic logic [127:0] blk4k(input int b);
        logic [127:0] r;
        r = '0;
        for (int k = 0; k < 16; k++) r[127-8*k -: 8] = mem4k[b*16 + k];
        return r;
    endfunction

    task automatic chk(input bit ok, input string nm,
                       input string act, input string req);
        n_chk++;
        if (!ok) begin
            n_err++;
            $display("FAIL %s: got %s, required %s", nm, act, req);
        end
    endtask

    // Scoreboards: pop and compare on each accepted block.
    always @(negedge clk) begin
        if (!rst && v32 && rdy32) begin
            if (q32.size() == 0) begin
                n_chk++; n_err++;
                $display("FAIL sb32: got %h, required no block", d32);
            end else begin
                e32 = q32.pop_front();
                chk(d32 === e32, "sb32",
                    $sformatf("%h", d32), $sformatf("%h", e32));
            end
        end
        if (!rst && v4k && rdy4k) begin
            hs4k++;
            if (q4k.size() == 0) begin
                n_chk++; n_err++;
                $display("FAIL sb4k: got %h, required no block", d4k);
            end else begin
                e4k = q4k.pop_front();
                chk(d4k === e4k, "sb4k",
                    $sformatf("%h", d4k), $sformatf("%h", e4k));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push32();
        q32.push_back(blk32(0));
        q32.push_back(blk32(1));
    endtask

    task automatic wait_done32();
        for (int i = 0; i < 200 && !done32; i++) tick();
        chk(done32 === 1'b1, "done32_timeout",
            $sformatf("%b", done32), "1");
    endtask

    task automatic wait_valid32();
        for (int i = 0; i < 40 && !v32; i++) tick();
        chk(v32 === 1'b1, "valid32_timeout",
            $sformatf("%b", v32), "1");
    endtask

    typedef struct {
        int           k;
        logic         en;
        logic [4:0]   addr;
        logic         vld;
        logic         bsy;
        logic         dn;
        logic [127:0] data;
    } vec_t;

    vec_t tbl[8];

    initial begin
        bit ok;
        int k;
        int bad;

        for (int i = 0; i < 4096; i++) mem4k[i] = 8'($urandom);

        tbl[0] = '{0,  1'b1, 5'd0,  1'b0, 1'b1, 1'b0, '0};
        tbl[1] = '{7,  1'b1, 5'd7,  1'b0, 1'b1, 1'b0, '0};
        tbl[2] = '{15, 1'b1, 5'd15, 1'b0, 1'b1, 1'b0, '0};
        tbl[3] = '{16, 1'b0, 5'd0,  1'b0, 1'b1, 1'b0, '0};
        tbl[4] = '{17, 1'b0, 5'd0,  1'b1, 1'b1, 1'b0, blk32(0)};
        tbl[5] = '{18, 1'b1, 5'd16, 1'b0, 1'b1, 1'b0, '0};
        tbl[6] = '{35, 1'b0, 5'd0,  1'b1, 1'b1, 1'b0, blk32(1)};
        tbl[7] = '{36, 1'b0, 5'd0,  1'b0, 1'b0, 1'b1, '0};

        // Reset state
        tick(); tick();
        ok = !en32 && !v32 && !busy32 && !done32 &&
             a32 == 0 && d32 == 0;
        chk(ok, "reset_state",
            $sformatf("en=%b v=%b b=%b d=%b a=%h", en32, v32, busy32,
                      done32, a32), "all zero");
        rst = 1'b0;
        tick();

        // Nominal run against the timing table
        push32();
        start32 = 1'b1;
        tick();
        k = 0;
        foreach (tbl[i]) begin
            while (k < tbl[i].k) begin tick(); k++; end
            ok = en32 === tbl[i].en && v32 === tbl[i].vld &&
                 busy32 === tbl[i].bsy && done32 === tbl[i].dn &&
                 (!tbl[i].en || a32 === tbl[i].addr) &&
                 (!tbl[i].vld || d32 === tbl[i].data);
            chk(ok, $sformatf("tbl_k%0d", tbl[i].k),
                $sformatf("en=%b a=%h v=%b b=%b d=%b data=%h",
                          en32, a32, v32, busy32, done32, d32),
                $sformatf("en=%b a=%h v=%b b=%b d=%b data=%h",
                          tbl[i].en, tbl[i].addr, tbl[i].vld,
                          tbl[i].bsy, tbl[i].dn, tbl[i].data));
        end

        // done holds while start stays high
        for (int i = 0; i < 5; i++) begin
            tick();
            chk(done32 === 1'b1, "done_hold",
                $sformatf("%b", done32), "1");
        end
        start32 = 1'b0;
        tick();
        chk(done32 === 1'b0 && busy32 === 1'b0, "done_drop",
            $sformatf("done=%b busy=%b", done32, busy32), "0 0");
        chk(q32.size() == 0, "run1_blocks",
            $sformatf("%0d left", q32.size()), "0 left");

        // Backpressure; also a fresh run from addr 0
        rdy32 = 1'b0;
        push32();
        start32 = 1'b1;
        tick();
        chk(en32 === 1'b1 && a32 === 5'd0, "restart_addr0",
            $sformatf("en=%b a=%h", en32, a32), "en=1 a=00");
        wait_valid32();
        for (int i = 0; i < 10; i++) begin
            tick();
            ok = v32 === 1'b1 && en32 === 1'b0 && d32 === blk32(0);
            chk(ok, "backpressure",
                $sformatf("v=%b en=%b data=%h", v32, en32, d32),
                $sformatf("v=1 en=0 data=%h", blk32(0)));
        end
        rdy32 = 1'b1;
        tick();
        ok = v32 === 1'b0 && en32 === 1'b1 && a32 === 5'd16;
        chk(ok, "bp_accept",
            $sformatf("v=%b en=%b a=%h", v32, en32, a32),
            "v=0 en=1 a=10");
        wait_done32();
        start32 = 1'b0;
        tick();

        // Abort during FETCH
        push32();
        start32 = 1'b1;
        tick();
        for (int i = 0; i < 6; i++) tick();
        start32 = 1'b0;
        tick();
        ok = en32 === 1'b0 && busy32 === 1'b0 && v32 === 1'b0;
        chk(ok, "abort_idle",
            $sformatf("en=%b b=%b v=%b", en32, busy32, v32), "0 0 0");
        ok = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (v32 !== 1'b0) ok = 1'b0;
        end
        chk(ok, "abort_no_valid", "valid seen", "no valid");
        q32.delete();
        push32();
        start32 = 1'b1;
        wait_done32();
        chk(q32.size() == 0, "abort_restart_blocks",
            $sformatf("%0d left", q32.size()), "0 left");
        start32 = 1'b0;
        tick();

        // Asynchronous reset in SEND
        rdy32 = 1'b0;
        push32();
        start32 = 1'b1;
        tick();
        wait_valid32();
        tick();
        #2 rst = 1'b1;
        #1;
        ok = !en32 && !v32 && !busy32 && !done32 &&
             a32 == 0 && d32 == 0;
        chk(ok, "async_reset",
            $sformatf("en=%b v=%b b=%b d=%b a=%h data=%h", en32, v32,
                      busy32, done32, a32, d32), "all zero");
        q32.delete();
        tick(); tick();
        push32();
        rdy32 = 1'b1;
        rst = 1'b0;
        for (int i = 0; i < 5 && !en32; i++) tick();
        chk(en32 === 1'b1 && a32 === 5'd0, "post_reset_addr0",
            $sformatf("en=%b a=%h", en32, a32), "en=1 a=00");
        wait_done32();
        chk(q32.size() == 0, "post_reset_blocks",
            $sformatf("%0d left", q32.size()), "0 left");
        start32 = 1'b0;
        tick();

        // Full image with random ready
        for (int b = 0; b < 256; b++) q4k.push_back(blk4k(b));
        start4k = 1'b1;
        for (int i = 0; i < 30000 && !done4k; i++) begin
            tick();
            rdy4k = 1'($urandom_range(0, 1));
        end
        chk(done4k === 1'b1, "done4k_timeout",
            $sformatf("%b", done4k), "1");
        chk(hs4k == 256 && busy4k === 1'b0, "hs4k_count",
            $sformatf("hs=%0d busy=%b", hs4k, busy4k), "hs=256 busy=0");
        chk(q4k.size() == 0, "q4k_empty",
            $sformatf("%0d left", q4k.size()), "0 left");
        bad = 0;
        for (int i = 0; i < 4096; i++) if (rc4k[i] != 1) bad++;
        chk(bad == 0, "reads_once",
            $sformatf("%0d bad addrs", bad), "0 bad addrs");
        start4k = 1'b0;
        tick();
        chk(done4k === 1'b0, "done4k_drop",
            $sformatf("%b", done4k), "0");

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/image_block_reader.md
# image_block_reader

Streams a plaintext image out of a byte-wide synchronous memory as 128-bit AES blocks. It is the responder on the controller's reader start/done handshake. On start it fetches the image 16 bytes at a time, packs each block big-endian, and offers it to the AES datapath over a valid/ready interface. When the last block has been accepted it raises done and holds it until the controller withdraws start.

## Interface
- IMG_BYTES, default 4096: image size in bytes; must be a nonzero multiple of 16 (elaboration-time check).
- ADDR_W, default 12: memory address width; 2^ADDR_W >= IMG_BYTES.
- clk  in  1  single clock; all logic on rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  level request from controller; held high until done seen.
- done  out  1  level; high from final block acceptance until start low.
- busy  out  1  high while fetching/sending (not IDLE, not DONE).
- mem_en  out  1  memory read enable (registered).
- mem_addr  out  ADDR_W  byte address (registered).
- mem_rdata  in  8  read data, valid one cycle after the mem_en/mem_addr edge.
- blk_data  out  128  packed block; byte at lowest address in [127:120].
- blk_valid  out  1  block offered.
- blk_ready  in  1  AES datapath accepts when blk_valid && blk_ready.

## Operation
- States: IDLE, FETCH, DRAIN, SEND, DONE.
- IDLE: outputs low, counters zero. start=1 -> FETCH, mem_en=1, mem_addr=0.
- FETCH: 16 cycles, mem_addr increments by 1 each cycle. Each returned byte is shifted into the packer one cycle after its address. After the 16th address -> DRAIN, mem_en=0.
- DRAIN: one cycle capturing byte 15. -> SEND, blk_valid=1.
- SEND: blk_data/blk_valid are stable until handshake.
  - Handshake with blocks remaining -> FETCH; blk_valid=0; mem_en=1 with next block's base address on the same edge.
  - Handshake on final block -> DONE; done=1, busy=0.
- DONE: done held while start=1. start=0 -> IDLE, done=0.
- Block count = IMG_BYTES/16; byte address = block*16 + k, no wrap.
- start dropped in FETCH/DRAIN/SEND (protocol violation): abort to IDLE next edge. blk_valid, mem_en and busy are cleared and counters zeroed; no partial block is emitted.
- start held high in IDLE after a completed run cannot occur (done holds until start low). A new run needs start low then high.
- rst at any time: immediately IDLE. done, busy, mem_en, blk_valid = 0; mem_addr = 0; blk_data = 0.

## Timing
- Edge E0 samples start=1 in IDLE: mem_en=1, addr=0 after E0. addr=15 after E15. Byte 15 captured at E17. blk_valid=1 after E17 (17-cycle latency).
- Handshake at edge Eh: next block's blk_valid rises after Eh+17. Throughput is 18 cycles per block with blk_ready tied high.
- Final handshake edge Eh: done=1 after Eh. start=0 sampled at Ed: done=0 after Ed.
- blk_ready is ignored outside SEND. blk_valid never depends combinationally on blk_ready.

## Structure
- Shared package aes_pkg: AES_BLOCK_BITS=128, BYTES_PER_BLOCK=16, reader state encoding.
- One sub-module, block_packer: a 16-byte shift-left register with load-enable and clear. The top level holds the FSM, byte counter, block counter and address register.

## Test plan
- IMG_BYTES=32, mem[i]=i, blk_ready=1. Pulse start high and hold. Required:
  - blk_data=0x000102…0f 17 cycles after start is sampled.
  - then 0x101112…1f.
  - done=1 after the second handshake.
  - busy=0 after the second handshake.
- Backpressure: hold blk_ready=0 for 10 cycles in SEND -> blk_data/blk_valid unchanged, mem_en=0 throughout. Accepted on the ready edge.
- Completion handshake: keep start=1 for 5 cycles after done -> done stays 1. Drop start -> done=0 next edge. Reassert start -> fresh run begins at addr 0.
- Abort: drop start at FETCH cycle 7 -> IDLE next edge, mem_en=0, no blk_valid. Restart yields block 0 = 0x000102…0f.
- Reset mid-SEND with blk_valid=1 -> all outputs 0 asynchronously. After release with start=1, the first block fetches from addr 0.
- IMG_BYTES=4096, random blk_ready (50%) -> exactly 256 handshakes, addresses 0..4095 each read once, done after the 256th.
